// File: rtl/window_gen_3x3.sv
// Sliding 3x3 window generator: two line buffers plus a 3x3 register window,
// turning a raster pixel stream into neighbourhoods for the Sobel stage.
module window_gen_3x3 #(
  parameter int NBIT       = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic [NBIT-1:0] i_pixel,
  input  logic            i_pixel_valid,
  input  logic            i_sof,
  output logic [NBIT-1:0] o_data [3][3],
  output logic            o_data_valid,
  output logic            o_frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  logic [CW-1:0]   col, cur_col;
  logic [RW-1:0]   row, cur_row;
  logic [NBIT-1:0] lb0 [IMG_WIDTH];
  logic [NBIT-1:0] lb1 [IMG_WIDTH];
  logic [NBIT-1:0] lb0_rd, lb1_rd;
  logic            at_line_end, at_frame_end, window_ok;

  // A start-of-frame pixel is treated as (0,0) whatever the counters hold
  always_comb begin
    cur_col      = i_sof ? '0 : col;
    cur_row      = i_sof ? '0 : row;
    lb0_rd       = lb0[cur_col];
    lb1_rd       = lb1[cur_col];
    at_line_end  = (cur_col == COL_LAST);
    at_frame_end = at_line_end && (cur_row == ROW_LAST);
    window_ok    = (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
  end

  always_ff @(posedge i_clk) begin
    if (i_rstn && i_pixel_valid) begin
      lb1[cur_col] <= lb0_rd;
      lb0[cur_col] <= i_pixel;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      col          <= '0;
      row          <= '0;
      o_data_valid <= 1'b0;
      o_frame_done <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          o_data[r][c] <= '0;
    end else begin
      o_data_valid <= 1'b0;
      o_frame_done <= 1'b0;
      if (i_pixel_valid) begin
        for (int r = 0; r < 3; r++) begin
          o_data[r][0] <= o_data[r][1];
          o_data[r][1] <= o_data[r][2];
        end
        o_data[0][2] <= lb1_rd;
        o_data[1][2] <= lb0_rd;
        o_data[2][2] <= i_pixel;
        o_data_valid <= window_ok;
        o_frame_done <= at_frame_end;
        if (at_line_end) begin
          col <= '0;
          row <= (cur_row == ROW_LAST) ? '0 : cur_row + ROW_ONE;
        end else begin
          col <= cur_col + COL_ONE;
          row <= cur_row;
        end
      end
    end
  end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3 on a 5x4 image with pixel = base + row*16 + col.
module tb_window_gen_3x3;

  localparam int NBIT = 8;
  localparam int W    = 5;
  localparam int H    = 4;

  logic            i_clk = 1'b0;
  logic            i_rstn;
  logic [NBIT-1:0] i_pixel;
  logic            i_pixel_valid;
  logic            i_sof;
  logic [NBIT-1:0] o_data [3][3];
  logic            o_data_valid;
  logic            o_frame_done;

  typedef struct {
    logic [7:0]             pixel;
    logic                   valid;
    logic                   sof;
    logic                   exp_valid;
    logic                   exp_done;
    logic [2:0][2:0][7:0]   exp_win;
  } vec_t;

  vec_t vecs[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   n_windows = 0;
  int   n_done    = 0;

  window_gen_3x3 #(.NBIT(NBIT), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_pixel      (i_pixel),
    .i_pixel_valid(i_pixel_valid),
    .i_sof        (i_sof),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_frame_done (o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  // Expected window for pixel (r,c) is centred on (r-1,c-1) of the same frame
  task automatic add_frame(input logic [7:0] base, input bit sof_first, input int max_gap,
                           input int n_pix, input bit flat);
    vec_t v;
    for (int p = 0; p < n_pix; p++) begin
      int r = p / W;
      int c = p % W;
      int gaps = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gaps; g++) begin
        v = '{pixel: 8'h00, valid: 1'b0, sof: 1'b0, exp_valid: 1'b0, exp_done: 1'b0, exp_win: '0};
        vecs.push_back(v);
      end
      v.pixel     = flat ? base : 8'(base + r * 16 + c);
      v.valid     = 1'b1;
      v.sof       = sof_first && (p == 0);
      v.exp_valid = (r >= 2) && (c >= 2);
      v.exp_done  = (r == H - 1) && (c == W - 1);
      v.exp_win   = '0;
      if (v.exp_valid)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            v.exp_win[i][j] = flat ? base : 8'(base + (r - 2 + i) * 16 + (c - 2 + j));
      vecs.push_back(v);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    i_pixel       = v.pixel;
    i_pixel_valid = v.valid;
    i_sof         = v.sof;
    @(negedge i_clk);
    i_pixel_valid = 1'b0;
    i_sof         = 1'b0;
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    logic [2:0][2:0][7:0] act;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        act[i][j] = o_data[i][j];
    check_val({tag, " valid"}, int'(o_data_valid), int'(v.exp_valid));
    check_val({tag, " frame_done"}, int'(o_frame_done), int'(v.exp_done));
    if (v.exp_valid) begin
      n_checks++;
      if (act !== v.exp_win) begin
        n_fail++;
        $display("[TB] FAIL %s window: got %h expected %h", tag, act, v.exp_win);
      end
    end
    if (o_data_valid) n_windows++;
    if (o_frame_done) n_done++;
  endtask

  task automatic run_table(input string tag);
    foreach (vecs[k]) begin
      applyStimulus(vecs[k]);
      checkOutput(vecs[k], tag);
    end
    vecs.delete();
  endtask

  task automatic check_reset_state(input string tag);
    int nz = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        if (o_data[i][j] !== 8'h00) nz++;
    check_val({tag, " valid"}, int'(o_data_valid), 0);
    check_val({tag, " frame_done"}, int'(o_frame_done), 0);
    check_val({tag, " nonzero window entries"}, nz, 0);
  endtask

  task automatic check_counts(input string tag, input int exp_win, input int exp_done);
    check_val({tag, " window count"}, n_windows, exp_win);
    check_val({tag, " frame_done count"}, n_done, exp_done);
    n_windows = 0;
    n_done    = 0;
  endtask

  initial begin
    int gx, gy;
    i_rstn        = 1'b0;
    i_pixel       = '0;
    i_pixel_valid = 1'b0;
    i_sof         = 1'b0;
    repeat (2) @(negedge i_clk);
    check_reset_state("reset");
    i_rstn = 1'b1;

    // Continuous frame, with spot checks of the first and last windows
    add_frame(8'h00, 1'b1, 0, W * H, 1'b0);
    foreach (vecs[k]) begin
      applyStimulus(vecs[k]);
      checkOutput(vecs[k], "frame");
      if (k == 12) begin
        check_val("first [0][0]", int'(o_data[0][0]), 'h00);
        check_val("first [1][1]", int'(o_data[1][1]), 'h11);
        check_val("first [2][2]", int'(o_data[2][2]), 'h22);
      end
      if (k == 19) begin
        check_val("last [0][0]", int'(o_data[0][0]), 'h12);
        check_val("last [2][2]", int'(o_data[2][2]), 'h34);
        check_val("last frame_done", int'(o_frame_done), 1);
      end
    end
    vecs.delete();
    check_counts("frame", 6, 1);

    add_frame(8'h00, 1'b1, 3, W * H, 1'b0);
    run_table("gaps");
    check_counts("gaps", 6, 1);

    add_frame(8'h00, 1'b1, 0, W * H, 1'b0);
    add_frame(8'h80, 1'b0, 0, W * H, 1'b0);
    run_table("b2b");
    check_counts("b2b", 12, 2);

    // Abort after pixel (2,2); the sof pixel lands where (2,3) would have been
    add_frame(8'h00, 1'b1, 0, 13, 1'b0);
    add_frame(8'h80, 1'b1, 0, W * H, 1'b0);
    run_table("sof_abort");
    check_counts("sof_abort", 7, 1);

    add_frame(8'h00, 1'b1, 0, 12, 1'b0);
    run_table("pre_reset");
    i_rstn = 1'b0;
    @(negedge i_clk);
    check_reset_state("mid_reset");
    i_rstn = 1'b1;
    n_windows = 0;
    n_done    = 0;
    add_frame(8'h80, 1'b0, 0, W * H, 1'b0);
    run_table("post_reset");
    check_counts("post_reset", 6, 1);

    // Sobel gradients on a flat frame must vanish
    add_frame(8'h40, 1'b1, 1, W * H, 1'b1);
    foreach (vecs[k]) begin
      applyStimulus(vecs[k]);
      checkOutput(vecs[k], "flat");
      if (o_data_valid) begin
        gx = (int'(o_data[0][2]) + 2 * int'(o_data[1][2]) + int'(o_data[2][2]))
           - (int'(o_data[0][0]) + 2 * int'(o_data[1][0]) + int'(o_data[2][0]));
        gy = (int'(o_data[2][0]) + 2 * int'(o_data[2][1]) + int'(o_data[2][2]))
           - (int'(o_data[0][0]) + 2 * int'(o_data[0][1]) + int'(o_data[0][2]));
        check_val("sobel gx", gx, 0);
        check_val("sobel gy", gy, 0);
      end
    end
    vecs.delete();
    check_counts("flat", 6, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
